rat_interrupt_controller: RTL
=============================

// Module: rat_interrupt_controller
// PURPOSE
//  Collects up to NUM_SRC peripheral interrupt lines for the RAT CPU, latches edges as pending,
//  masks/prioritises them and drives the single INTERRUPT input of the CPU control unit.
//  Hands the winning source ID to the ISR over the IN/OUT port bus; ISR ends service with an EOI write.
//  Sits between the peripherals, the control unit (INTERRUPT/INT_ACK) and the CPU I/O port mux.
// PARAMETERS
//  NUM_SRC    8      number of interrupt sources, 1..8
//  MASK_RST   8'h00  reset value of mask register (1 = source enabled)
// PORTS
//  CLK        in   1        system clock, all state on posedge
//  RESET      in   1        synchronous, active-high reset
//  IRQ_IN     in   NUM_SRC  peripheral request lines, rising edge = one event, already in CLK domain
//  I_EN       in   1        CPU interrupt-enable flag (I flag)
//  INT_ACK    in   1        one-cycle pulse from control unit while in its interrupt state
//  PORT_ID    in   8        CPU I/O port address
//  OUT_PORT   in   8        CPU output data
//  IO_STRB    in   1        CPU output strobe, one cycle
//  IN_DATA    out  8        read data for CPU IN mux (combinational on PORT_ID)
//  INTERRUPT  out  1        registered interrupt request to control unit
// BEHAVIOUR
//  Reset: pending=0, mask=MASK_RST, irq_q=0, ACTIVE_ID=0, state=IDLE, INTERRUPT=0; IN_DATA follows PORT_ID.
//  Edge detect: irq_q<=IRQ_IN each cycle; pending[i] set when IRQ_IN[i]&~irq_q[i].
//  Latency: IRQ_IN rises before posedge k -> pending set after k -> INTERRUPT=1 after k+1 (if eligible).
//  Eligible = pending & mask (masked pending bits are retained, not lost).
//  Registers (port addresses in package): MASK_PORT 0x40 R/W; PEND_PORT 0x41 R, write-1-to-clear;
//   ID_PORT 0x42 R = {in_service,4'b0,ACTIVE_ID[2:0]}; EOI_PORT 0x43 W, data ignored.
//  Writes take effect at posedge when IO_STRB=1 and PORT_ID matches; unmatched ports ignored; IN_DATA=0.
//  FSM states:
//   IDLE:    INTERRUPT=0. If |eligible & I_EN -> REQ, INTERRUPT<=1.
//   REQ:     INTERRUPT=1. CAND_ID re-evaluated every cycle. INT_ACK -> latch ACTIVE_ID<=CAND_ID,
//            clear pending[CAND_ID], INTERRUPT<=0, -> SERVICE. No eligible source (cleared/masked)
//            or I_EN=0, without ack -> IDLE, INTERRUPT<=0.
//   SERVICE: INTERRUPT=0, in_service=1. EOI write -> IDLE. Further pending events accumulate.
//  INT_ACK outside REQ: ignored. EOI outside SERVICE: ignored.
//  Simultaneous: new edge and W1C/ack-clear on same bit same cycle -> bit stays set (set wins).
//  Simultaneous mask write and INT_ACK: ack uses CAND_ID computed from pre-write mask.
//  Edge while same bit already pending: merged (single event).
//  RESET mid-REQ/SERVICE: returns to IDLE next cycle, INTERRUPT=0, all pending dropped.
//  Only sources with index < NUM_SRC exist; higher bits of mask/pend read 0, writes ignored.
// CONFIGURATION
//  INTC_ROUND_ROBIN_EN undefined: fixed priority, source 0 highest.
//  INTC_ROUND_ROBIN_EN defined: rotating base pointer, reset 0; on INT_ACK base<=(ACTIVE_ID+1)
//   mod NUM_SRC; search starts at base, wraps at NUM_SRC-1 -> 0.
// STRUCTURE
//  Package rat_intc_pkg: state enum {IDLE,REQ,SERVICE}, port address localparams, ID width constant.
//  Sub-module rat_intc_prio_enc: combinational (eligible, base) -> (valid, id); base tied 0 when
//   INTC_ROUND_ROBIN_EN undefined.
// TESTING
//  1 mask=0xFF, I_EN=1, pulse IRQ_IN[3] -> INTERRUPT high 2 cycles later; ack -> ID_PORT reads 0x83.
//  2 IRQ_IN[5] and [2] same cycle, fixed prio -> ID 2 first; EOI -> INTERRUPT again, ID 5.
//  3 mask=0x00, pulse IRQ_IN[1] -> no INTERRUPT, PEND_PORT=0x02; write mask=0x02 -> INTERRUPT rises.
//  4 in REQ, W1C PEND_PORT 0x08 same cycle as new IRQ_IN[3] edge -> pending[3] stays 1.
//  5 ROUND_ROBIN_EN: sources 0,1 always re-pending, service 0 -> next ID 1, then 0 again.
//  6 RESET asserted in SERVICE -> next cycle INTERRUPT=0, PEND=0, ID_PORT=0x00, mask=MASK_RST.

Source files
------------

// File: rtl/rat_intc_pkg.sv
// Shared definitions for the RAT interrupt controller: FSM states,
// I/O port addresses and the source-ID width.
package rat_intc_pkg;

    // Width of a source ID (up to 8 sources)
    localparam int ID_W = 3;

    // CPU I/O port map
    localparam logic [7:0] MASK_PORT = 8'h40;  // R/W enable mask
    localparam logic [7:0] PEND_PORT = 8'h41;  // R, write-1-to-clear
    localparam logic [7:0] ID_PORT   = 8'h42;  // R {in_service,4'b0,id}
    localparam logic [7:0] EOI_PORT  = 8'h43;  // W, data ignored

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_e;

endpackage

// File: rtl/rat_intc_prio_enc.sv
// Priority encoder over the eligible sources. The search starts at base_i
// and wraps from NUM_SRC-1 back to 0; with base_i = 0 it is plain fixed
// priority with source 0 highest.
module rat_intc_prio_enc
    import rat_intc_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] eligible_i,
    input  logic [ID_W-1:0]    base_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    // Two passes: first the sources at or above the base, then the full set.
    // The second pass only fires when nothing at/above the base is eligible,
    // so it effectively picks the lowest index below the base (the wrap).
    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!valid_o && eligible_i[i] && (i >= int'(base_i))) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!valid_o && eligible_i[i]) begin
                valid_o = 1'b1;
                id_o    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rat_interrupt_controller.sv
// RAT CPU interrupt controller: latches rising edges of up to NUM_SRC
// peripheral lines as pending, masks and prioritises them, raises the
// registered INTERRUPT request, hands the winning ID to the ISR through
// the I/O port bus and waits for an EOI write before requesting again.
// Build option: define INTC_ROUND_ROBIN_EN for rotating priority
// (search base moves past each acknowledged source); otherwise fixed
// priority with source 0 highest.
module rat_interrupt_controller
    import rat_intc_pkg::*;
#(
    parameter int         NUM_SRC  = 8,
    parameter logic [7:0] MASK_RST = 8'h00
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    input  logic               I_EN,
    input  logic               INT_ACK,
    input  logic [7:0]         PORT_ID,
    input  logic [7:0]         OUT_PORT,
    input  logic               IO_STRB,
    output logic [7:0]         IN_DATA,
    output logic               INTERRUPT
);

    intc_state_e        state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    act_id_q, act_id_d;
    logic               int_q, int_d;

    logic               wr_mask, wr_pend, wr_eoi;
    logic [NUM_SRC-1:0] rise, eligible, ack_clr, w1c_clr;
    logic               cand_vld, ack_fire;
    logic [ID_W-1:0]    cand_id, base;
    logic [7:0]         mask8, pend8;

    assign wr_mask = IO_STRB && (PORT_ID == MASK_PORT);
    assign wr_pend = IO_STRB && (PORT_ID == PEND_PORT);
    assign wr_eoi  = IO_STRB && (PORT_ID == EOI_PORT);

    assign rise     = IRQ_IN & ~irq_q;
    assign eligible = pend_q & mask_q;
    assign w1c_clr  = wr_pend ? OUT_PORT[NUM_SRC-1:0] : '0;

    // Ack only counts while requesting and a candidate exists. The candidate
    // comes from the current (pre-write) mask, so a same-cycle mask write
    // cannot change which source is handed out.
    assign ack_fire = (state_q == REQ) && INT_ACK && cand_vld;

    rat_intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio (
        .eligible_i (eligible),
        .base_i     (base),
        .valid_o    (cand_vld),
        .id_o       (cand_id)
    );

`ifdef INTC_ROUND_ROBIN_EN
    logic [ID_W-1:0] base_q, base_d;

    // Rotate the search start to just past the source being acknowledged
    always_comb begin
        base_d = base_q;
        if (ack_fire) begin
            base_d = (cand_id == ID_W'(NUM_SRC - 1)) ? '0 : cand_id + ID_W'(1);
        end
    end

    // Round-robin base register
    always_ff @(posedge CLK) begin
        if (RESET) base_q <= '0;
        else       base_q <= base_d;
    end

    assign base = base_q;
`else
    assign base = '0;
`endif

    // One-hot clear of the source handed out on acknowledge
    always_comb begin
        ack_clr = '0;
        if (ack_fire) ack_clr[cand_id] = 1'b1;
    end

    // Pending/mask next state: clears first, new edges last so set wins
    always_comb begin
        pend_d = (pend_q & ~w1c_clr & ~ack_clr) | rise;
        mask_d = wr_mask ? OUT_PORT[NUM_SRC-1:0] : mask_q;
    end

    // Request/service sequencing and the registered INTERRUPT output
    always_comb begin
        state_d  = state_q;
        act_id_d = act_id_q;
        case (state_q)
            IDLE: begin
                if (cand_vld && I_EN) state_d = REQ;
            end
            REQ: begin
                if (ack_fire) begin
                    state_d  = SERVICE;
                    act_id_d = cand_id;
                end else if (!cand_vld || !I_EN) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wr_eoi) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        int_d = (state_d == REQ);
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            irq_q    <= '0;
            pend_q   <= '0;
            mask_q   <= MASK_RST[NUM_SRC-1:0];
            act_id_q <= '0;
            int_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            irq_q    <= IRQ_IN;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            act_id_q <= act_id_d;
            int_q    <= int_d;
        end
    end

    assign INTERRUPT = int_q;

    // CPU IN mux; non-existent source bits read as 0
    always_comb begin
        mask8                = '0;
        pend8                = '0;
        mask8[NUM_SRC-1:0]   = mask_q;
        pend8[NUM_SRC-1:0]   = pend_q;
        case (PORT_ID)
            MASK_PORT: IN_DATA = mask8;
            PEND_PORT: IN_DATA = pend8;
            ID_PORT:   IN_DATA = {(state_q == SERVICE), 4'b0000, act_id_q};
            default:   IN_DATA = 8'h00;
        endcase
    end

endmodule
